ct_loader: RTL and testbench
============================

Name: ct_loader

Overview:
- Streaming loader that fills the ciphertext memory (ct_mem) consumed by the crack engine.
- Accepts a length-prefixed byte stream over a valid/ready handshake and writes the length to address 0 and the payload bytes to addresses 1..L.
- Asserts done when the image is complete, which tells the top level it may release the crack engine's enable.
- Also reports a running XOR checksum of the payload and flags oversize messages.

Parameters:
- ADDR_W, 8, width of the ct_mem address bus.
- MAX_LEN, 255, largest legal payload length L; must be ≤ 2^ADDR_W − 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- ct_addr  output  ADDR_W  ct_mem write address.
- ct_wrdata  output  8  ct_mem write data.
- ct_wren  output  1  ct_mem write enable.
- busy  output  1  high in LEN, DATA, FLUSH.
- done  output  1  level; image complete and valid.
- err  output  1  level; length exceeded MAX_LEN.
- checksum  output  8  XOR of all payload bytes written; meaningful when done=1.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - in_ready, ct_wren, busy, done, err = 0.
  - ct_addr, ct_wrdata, checksum = 0.
  - Payload counter = 0.
  - ct_mem contents are not cleared.
- Acceptance: a byte is accepted in cycle N iff in_valid && in_ready in N.
- Write latency: an accepted byte is written in cycle N+1. ct_wren=1 for exactly one cycle, with ct_addr/ct_wrdata registered alongside it. One byte per cycle sustained; no bubbles are inserted by the loader.
- States:
  - IDLE: in_ready=0. start → LEN.
  - LEN: in_ready=1. On accept of byte L:
    - If L > MAX_LEN → ERR; nothing is written.
    - Otherwise: write (addr 0, L); latch L; counter := 0; checksum := 0.
      - L==0 → FLUSH.
      - L>0 → DATA.
  - DATA: in_ready=1. On accept: write (addr counter+1, byte); checksum ^= byte; counter++. On accept with counter+1 == L → FLUSH, and in_ready drops the following cycle.
  - FLUSH: in_ready=0. Covers the cycle in which the final write is on the bus. Next cycle → DONE.
  - DONE: done=1; in_ready=0; checksum held. start → LEN, which clears done and checksum in the same transition.
  - ERR: err=1; in_ready=0. start → LEN (clears err).
- done timing: last byte accepted in cycle N → ct_wren in N+1 → done=1 from N+2.
- Boundary: start during LEN/DATA/FLUSH is ignored (no restart mid-load).
- Boundary: in_valid while in_ready=0 is not consumed. Upstream must hold data; the loader never drops bytes.
- Boundary: L==MAX_LEN writes addresses 0..MAX_LEN inclusive. Address arithmetic is ADDR_W-bit unsigned; no wrap occurs because MAX_LEN ≤ 2^ADDR_W − 1.
- Boundary: rst mid-load returns to IDLE next cycle with all outputs at reset values. A partial image remains in memory with done=0.
- Boundary: rst and start in the same cycle → rst wins.
- done and err are never both 1. busy = (state ∈ {LEN, DATA, FLUSH}).

Decomposition:
- Package ct_loader_pkg:
  - Enum state_t {IDLE, LEN, DATA, FLUSH, DONE, ERR}.
  - Constant LEN_ADDR = 0.
  - Constant PAYLOAD_BASE = 1.
- No sub-module: a single FSM with a registered write port; the checksum is an inline XOR register.

Test Plan:
- Reset then start; stream 0x03, 0xAA, 0x55, 0x0F back-to-back with in_valid held → writes (0,03), (1,AA), (2,55), (3,0F) on consecutive cycles; done=1 two cycles after the 0x0F accept; checksum=0xF0.
- Start; send 0x00 → single write (0,00); done=1 two cycles after accept; checksum=0x00; no further writes.
- MAX_LEN=16; start; send 0x11 → no ct_wren ever; err=1; in_ready=0. Then pulse start and send 0x01, 0x7E → err clears; writes (0,01), (1,7E); done=1; checksum=0x7E.
- Start; send 0x04 then payload with in_valid toggling 1,0,1,0 → only handshake cycles produce writes; addresses 1..4 are in order; in_ready stays 1 through the gaps.
- Start; send 0x05, 0x11, 0x22; assert rst; then start again → after rst, all outputs are 0 and state is IDLE. The new load with 0x01, 0x33 writes (0,01), (1,33); done=1; checksum=0x33.
- Complete a load; then pulse start in DONE and again mid-DATA → the first start clears done and re-enters LEN; the mid-DATA start has no effect on counter or addresses.

Source files
------------

// File: rtl/ct_loader_pkg.sv
// rtl/ct_loader_pkg.sv - shared types and address constants for the ciphertext loader
package ct_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        FLUSH,
        DONE,
        ERR
    } state_t;

    localparam int LEN_ADDR     = 0;
    localparam int PAYLOAD_BASE = 1;

endpackage

// File: rtl/ct_loader.sv
// rtl/ct_loader.sv - length-prefixed byte stream loader into ct_mem with XOR checksum
module ct_loader
    import ct_loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int MAX_LEN = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ct_addr,
    output logic [7:0]        ct_wrdata,
    output logic              ct_wren,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        checksum
);

    // Counter/length width covers both the 8-bit length byte and the address range.
    localparam int CW = (ADDR_W > 8) ? ADDR_W : 8;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wrdata_q, wrdata_d;
    logic              wren_q, wren_d;
    logic [7:0]        csum_q, csum_d;

    logic              accept;
    logic [CW-1:0]     byte_ext;
    logic [CW-1:0]     cnt_inc;

    assign in_ready = (state_q == LEN) || (state_q == DATA);
    assign busy     = (state_q == LEN) || (state_q == DATA) || (state_q == FLUSH);
    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);

    assign ct_addr   = addr_q;
    assign ct_wrdata = wrdata_q;
    assign ct_wren   = wren_q;
    assign checksum  = csum_q;

    assign accept   = in_valid && in_ready;
    assign byte_ext = CW'(in_data);
    assign cnt_inc  = cnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        wren_d   = 1'b0;
        csum_d   = csum_q;

        case (state_q)
            IDLE: begin
                if (start) state_d = LEN;
            end
            LEN: begin
                if (accept) begin
                    if (byte_ext > CW'(MAX_LEN)) begin
                        state_d = ERR;
                    end else begin
                        wren_d   = 1'b1;
                        addr_d   = ADDR_W'(LEN_ADDR);
                        wrdata_d = in_data;
                        len_d    = byte_ext;
                        cnt_d    = '0;
                        csum_d   = 8'h00;
                        state_d  = (in_data == 8'h00) ? FLUSH : DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    wren_d   = 1'b1;
                    addr_d   = ADDR_W'(cnt_q + CW'(PAYLOAD_BASE));
                    wrdata_d = in_data;
                    csum_d   = csum_q ^ in_data;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == len_q) state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            DONE, ERR: begin
                // Restart clears the previous result before the new length arrives.
                if (start) begin
                    state_d = LEN;
                    csum_d  = 8'h00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            wrdata_q <= 8'h00;
            wren_q   <= 1'b0;
            csum_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            wren_q   <= wren_d;
            csum_q   <= csum_d;
        end
    end

endmodule

// File: tb/tb_ct_loader.sv
// tb/tb_ct_loader.sv - scoreboard bench for ct_loader with random messages
module tb_ct_loader;

    localparam int ADDR_W  = 8;
    localparam int MAX_LEN = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] ct_addr;
    logic [7:0]        ct_wrdata;
    logic              ct_wren;
    logic              busy;
    logic              done;
    logic              err;
    logic [7:0]        checksum;

    ct_loader #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ct_addr  (ct_addr),
        .ct_wrdata(ct_wrdata),
        .ct_wren  (ct_wren),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write on the ct_mem port must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (ct_wren) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%0d expected none (cycle %0d)",
                         ct_addr, ct_wrdata, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", int'(ct_addr), e.addr);
                chk("wr_data", int'(ct_wrdata), e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
        if (done && err) chk("done_err_exclusive", 1, 0);
    end

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_ct_addr"}, int'(ct_addr), 0);
        chk({tag, "_ct_wrdata"}, int'(ct_wrdata), 0);
        chk({tag, "_ct_wren"}, int'(ct_wren), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_checksum"}, int'(checksum), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_done_clr", int'(done), 0);
        chk("start_err_clr", int'(err), 0);
        chk("start_ready", int'(in_ready), 1);
    endtask

    // Sends up to stop_after bytes of msg (length byte first). When the whole
    // message goes out, checks the completion (or error) outcome.
    task automatic send_msg(input logic [7:0] msg[$], input int gap_pct,
                            input bit noise, input int stop_after);
        int   len;
        bit   over;
        int   n;
        int   sent;
        int   t;
        int   gaps;
        logic [7:0] cs;
        len  = int'(msg[0]);
        over = len > MAX_LEN;
        n    = over ? 1 : len + 1;
        sent = (stop_after < n) ? stop_after : n;
        cs   = 8'h00;
        for (int k = 0; k < sent; k++) begin
            gaps = 0;
            while (gap_pct > 0 && gaps < 4 && int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                chk("ready_in_gap", int'(in_ready), 1);
                @(negedge clk);
                gaps++;
            end
            in_valid = 1'b1;
            in_data  = msg[k];
            start    = (noise && k > 0 && k == sent / 2) ? 1'b1 : 1'b0;
            t = 0;
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("ready_present", int'(in_ready), 1);
            if (!over) exp_q.push_back('{k, int'(msg[k]), cyc + 1});
            if (k > 0) cs ^= msg[k];
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        if (sent < n) return;
        if (over) begin
            chk("err_set", int'(err), 1);
            chk("err_ready", int'(in_ready), 0);
            chk("err_busy", int'(busy), 0);
            @(negedge clk);
            chk("err_hold", int'(err), 1);
            chk("err_done", int'(done), 0);
        end else begin
            chk("flush_done", int'(done), 0);
            chk("flush_busy", int'(busy), 1);
            chk("flush_ready", int'(in_ready), 0);
            @(negedge clk);
            chk("done_set", int'(done), 1);
            chk("done_err", int'(err), 0);
            chk("done_checksum", int'(checksum), int'(cs));
            chk("done_busy", int'(busy), 0);
            chk("done_ready", int'(in_ready), 0);
            chk("done_queue_empty", exp_q.size(), 0);
        end
    endtask

    task automatic reset_mid_load();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_mid");
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst_after");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m[$];
        int len;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        pulse_start();
        m = '{8'h03, 8'hAA, 8'h55, 8'h0F};
        send_msg(m, 0, 1'b0, 99);
        chk("fixed1_checksum", int'(checksum), 8'hF0);

        // Bytes offered while in DONE must not be consumed.
        in_valid = 1'b1;
        in_data  = 8'h99;
        repeat (3) begin
            @(negedge clk);
            chk("done_no_consume", int'(in_ready), 0);
        end
        in_valid = 1'b0;

        pulse_start();
        m = '{8'h00};
        send_msg(m, 0, 1'b0, 99);

        pulse_start();
        m = '{8'h11};
        send_msg(m, 0, 1'b0, 99);
        pulse_start();
        m = '{8'h01, 8'h7E};
        send_msg(m, 0, 1'b0, 99);
        chk("fixed3_checksum", int'(checksum), 8'h7E);

        pulse_start();
        m = '{8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
        send_msg(m, 50, 1'b1, 99);

        pulse_start();
        m = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_msg(m, 0, 1'b0, 3);
        reset_mid_load();
        pulse_start();
        m = '{8'h01, 8'h33};
        send_msg(m, 0, 1'b0, 99);
        chk("fixed5_checksum", int'(checksum), 8'h33);

        pulse_start();
        m = '{8'(MAX_LEN)};
        for (int i = 0; i < MAX_LEN; i++) m.push_back(8'($urandom));
        send_msg(m, 0, 1'b1, 99);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(9))
                0:       len = int'($urandom_range(255, MAX_LEN + 1));
                1:       len = 0;
                2:       len = MAX_LEN;
                default: len = int'($urandom_range(MAX_LEN, 1));
            endcase
            m = '{8'(len)};
            for (int i = 0; i < len && len <= MAX_LEN; i++) m.push_back(8'($urandom));
            pulse_start();
            if (len > 1 && len <= MAX_LEN && $urandom_range(9) == 0) begin
                send_msg(m, int'($urandom_range(50)), 1'($urandom), int'($urandom_range(len, 1)));
                reset_mid_load();
            end else begin
                send_msg(m, int'($urandom_range(50)), 1'($urandom), 999);
            end
        end

        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
